// File: rtl/fpu_pkg.sv
// Shared FPU definitions: flag bit positions, operand classes
// and canonical quiet-NaN construction for any format width.
package fpu_pkg;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  localparam int MAX_W = 128;

  typedef enum logic [1:0] {
    NORMAL,
    ZERO,
    INF,
    NAN
  } fp_class_e;

  function automatic logic [MAX_W-1:0] qnan(
    input int exp_w,
    input int man_w
  );
    logic [MAX_W-1:0] v;
    v = '0;
    for (int i = 0; i < exp_w; i++)
      v[man_w+i] = 1'b1;
    v[man_w-1] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/faddsub_pipe_if.sv
// Operand/result valid-ready streams of the FP add/sub pipe.
// The slave side is the pipe; the master side feeds and drains it.
interface faddsub_pipe_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic         op;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;
  logic [3:0]   flags;

  modport master (
    output in_valid, op, x1, x2, out_ready,
    input  in_ready, out_valid, y, flags
  );

  modport slave (
    input  in_valid, op, x1, x2, out_ready,
    output in_ready, out_valid, y, flags
  );
endinterface

// File: rtl/fpu_lzc.sv
// Leading-zero counter; an all-zero input yields W.
// Output width defaults to hold the value W.
module fpu_lzc #(
  parameter int W  = 8,
  parameter int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  a,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++)
      if (a[i]) cnt = CW'(W-1-i);
  end

endmodule

// File: rtl/faddsub_pipe.sv
// Three-stage FP adder/subtractor: align, add/normalise,
// round/pack, with valid/ready flow control and RNE rounding.
module faddsub_pipe
  import fpu_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic clk,
  input logic rstn,
  faddsub_pipe_if.slave bus
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int SW  = MAN_W + 4;
  localparam int SHW = $clog2(SW);
  localparam int LZW = $clog2(SW+1);
  localparam int XW  = EXP_W + LZW + 2;
  localparam logic [XW-1:0] EMAX =
    XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic            sign;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]   sa;
    logic [SW-1:0]   sb;
    logic            sub;
    fp_class_e       cls;
    logic            inv;
  } align_t;

  typedef struct packed {
    logic          sign;
    logic [XW-1:0] exp;
    logic [SW-1:0] sig;
    fp_class_e     cls;
    logic          inv;
  } norm_t;

  function automatic fp_class_e classify(
    input logic [EXP_W-1:0] e,
    input logic [MAN_W-1:0] m
  );
    if (&e) return (|m) ? NAN : INF;
    if (e == '0) return ZERO;
    return NORMAL;
  endfunction

  logic v1, v2, v3;
  logic en1, en2, en3;
  logic [W-1:0] y_q;
  logic [3:0]   f_q;

  assign en3 = !v3 || bus.out_ready;
  assign en2 = !v2 || en3;
  assign en1 = !v1 || en2;

  assign bus.in_ready  = en1;
  assign bus.out_valid = v3;
  assign bus.y         = y_q;
  assign bus.flags     = f_q;

  logic             s_a, s_b;
  logic [EXP_W-1:0] e_a, e_b;
  logic [MAN_W-1:0] m_a, m_b;
  fp_class_e        c_a, c_b;

  assign s_a = bus.x1[W-1];
  assign e_a = bus.x1[W-2 -: EXP_W];
  assign m_a = bus.x1[MAN_W-1:0];
  assign s_b = bus.x2[W-1] ^ bus.op;
  assign e_b = bus.x2[W-2 -: EXP_W];
  assign m_b = bus.x2[MAN_W-1:0];
  assign c_a = classify(e_a, m_a);
  assign c_b = classify(e_b, m_b);

  logic             swap;
  logic             s_sup, s_inf;
  logic [EXP_W-1:0] e_sup, e_inf, ediff;
  logic [MAN_W-1:0] m_sup, m_inf;
  fp_class_e        c_sup, c_inf;

  assign swap  = {e_b, m_b} > {e_a, m_a};
  assign s_sup = swap ? s_b : s_a;
  assign s_inf = swap ? s_a : s_b;
  assign e_sup = swap ? e_b : e_a;
  assign e_inf = swap ? e_a : e_b;
  assign m_sup = swap ? m_b : m_a;
  assign m_inf = swap ? m_a : m_b;
  assign c_sup = swap ? c_b : c_a;
  assign c_inf = swap ? c_a : c_b;
  assign ediff = e_sup - e_inf;

  logic [SHW-1:0]  sh;
  logic [SW-1:0]   sig_sup, ext_inf, sig_inf;
  logic [2*SW-1:0] shw;

  assign sh = (32'(ediff) > SW-1) ?
              SHW'(SW-1) : SHW'(ediff);
  assign sig_sup = (c_sup == NORMAL) ?
                   {1'b1, m_sup, 3'b000} : '0;
  assign ext_inf = (c_inf == NORMAL) ?
                   {1'b1, m_inf, 3'b000} : '0;
  assign shw = {ext_inf, {SW{1'b0}}} >> sh;
  assign sig_inf = {shw[2*SW-1:SW+1],
                    shw[SW] | (|shw[SW-1:0])};

  logic any_nan, a_inf, b_inf, inv_c, inf_c;
  align_t n1, r1;

  assign any_nan = (c_a == NAN) || (c_b == NAN);
  assign a_inf   = (c_a == INF);
  assign b_inf   = (c_b == INF);
  assign inv_c   = !any_nan && a_inf && b_inf &&
                   (s_a != s_b);
  assign inf_c   = !any_nan && !inv_c &&
                   (a_inf || b_inf);

  always_comb begin
    n1.sign = s_sup;
    n1.exp  = e_sup;
    n1.sa   = sig_sup;
    n1.sb   = sig_inf;
    n1.sub  = s_sup ^ s_inf;
    n1.cls  = NORMAL;
    n1.inv  = 1'b0;
    unique case (1'b1)
      any_nan: n1.cls = NAN;
      inv_c: begin
        n1.cls = NAN;
        n1.inv = 1'b1;
      end
      inf_c: begin
        n1.cls  = INF;
        n1.sign = a_inf ? s_a : s_b;
      end
      default: ;
    endcase
  end

  logic [SW:0]     sum;
  logic [LZW-1:0]  lz;
  norm_t           n2, r2;

  assign sum = r1.sub ?
    {1'b0, r1.sa} - {1'b0, r1.sb} :
    {1'b0, r1.sa} + {1'b0, r1.sb};

  fpu_lzc #(.W(SW), .CW(LZW)) u_lzc (
    .a   (sum[SW-1:0]),
    .cnt (lz)
  );

  always_comb begin
    n2.sign = r1.sign;
    n2.cls  = r1.cls;
    n2.inv  = r1.inv;
    if (sum[SW]) begin
      n2.sig = {sum[SW:2], sum[1] | sum[0]};
      n2.exp = XW'(r1.exp) + XW'(1);
    end else begin
      n2.sig = sum[SW-1:0] << lz;
      n2.exp = XW'(r1.exp) - XW'(lz);
    end
    // an exactly cancelled sum always packs as +0
    if (r1.cls == NORMAL && sum == '0)
      n2.cls = ZERO;
  end

  logic lsb, gb, rb, sb, rup, carry;
  logic uf, of, nrm;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] man3;
  logic [XW-1:0]    ex3;
  logic [W-1:0]     y3;
  logic [3:0]       f3;

  assign lsb   = r2.sig[3];
  assign gb    = r2.sig[2];
  assign rb    = r2.sig[1];
  assign sb    = r2.sig[0];
  assign rup   = gb & (rb | sb | lsb);
  assign mr    = {1'b0, r2.sig[SW-1:3]} +
                 {{(MAN_W+1){1'b0}}, rup};
  assign carry = mr[MAN_W+1];
  assign man3  = carry ? mr[MAN_W:1] :
                         mr[MAN_W-1:0];
  assign ex3   = r2.exp +
                 {{(XW-1){1'b0}}, carry};
  assign nrm   = (r2.cls == NORMAL);
  assign uf    = nrm && (ex3[XW-1] || ex3 == '0);
  assign of    = nrm && !uf && (ex3 >= EMAX);

  always_comb begin
    y3 = {r2.sign, ex3[EXP_W-1:0], man3};
    f3 = '0;
    f3[FLAG_INEXACT] = gb | rb | sb;
    unique case (1'b1)
      r2.cls == NAN: begin
        y3 = W'(qnan(EXP_W, MAN_W));
        f3 = '0;
        f3[FLAG_INVALID] = r2.inv;
      end
      r2.cls == INF: begin
        y3 = {r2.sign, {EXP_W{1'b1}},
              {MAN_W{1'b0}}};
        f3 = '0;
      end
      r2.cls == ZERO: begin
        y3 = '0;
        f3 = '0;
      end
      uf: begin
        y3 = {r2.sign, {(W-1){1'b0}}};
        f3 = '0;
        f3[FLAG_UNDERFLOW] = 1'b1;
        f3[FLAG_INEXACT]   = 1'b1;
      end
      of: begin
        y3 = {r2.sign, {EXP_W{1'b1}},
              {MAN_W{1'b0}}};
        f3 = '0;
        f3[FLAG_OVERFLOW] = 1'b1;
        f3[FLAG_INEXACT]  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1  <= 1'b0;
      v2  <= 1'b0;
      v3  <= 1'b0;
      y_q <= '0;
      f_q <= '0;
    end else begin
      if (en1) v1 <= bus.in_valid;
      if (en2) v2 <= v1;
      if (en3) v3 <= v2;
      if (en3 && v2) begin
        y_q <= y3;
        f_q <= f3;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en1 && bus.in_valid) r1 <= n1;
    if (en2 && v1) r2 <= n2;
  end

endmodule

// File: tb/tb_faddsub_pipe.sv
// Scoreboard bench for faddsub_pipe: single and half
// precision instances, directed vectors, stall and reset.
module tb_faddsub_pipe;

  typedef struct packed {
    logic [31:0] y;
    logic [3:0]  f;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  faddsub_pipe_if #(.W(32)) bus ();
  faddsub_pipe_if #(.W(16)) bus_h ();

  faddsub_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  faddsub_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_h)
  );

  int   total  = 0;
  int   passed = 0;
  exp_t q[$];
  exp_t qh[$];
  logic [31:0] nums [12];

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] req
  );
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h",
                  name, act, req);
  endtask

  task automatic issue(
    input bit          h,
    input logic        o,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] ey,
    input logic [3:0]  ef
  );
    int   n;
    logic rdy;
    n   = 0;
    rdy = 1'b0;
    if (h) begin
      bus_h.in_valid = 1'b1;
      bus_h.op = o;
      bus_h.x1 = a[15:0];
      bus_h.x2 = b[15:0];
    end else begin
      bus.in_valid = 1'b1;
      bus.op = o;
      bus.x1 = a;
      bus.x2 = b;
    end
    while (!rdy && n < 50) begin
      @(negedge clk);
      rdy = h ? bus_h.in_ready : bus.in_ready;
      @(posedge clk);
      n++;
    end
    if (rdy) begin
      if (h) qh.push_back({ey, ef});
      else   q.push_back({ey, ef});
    end else begin
      check("accept_timeout", 64'(rdy), 64'd1);
    end
    #1;
    bus.in_valid   = 1'b0;
    bus_h.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() + qh.size()) != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 64'(q.size() + qh.size()), 64'd0);
    #1;
  endtask

  exp_t        e, eh;
  logic        hold_v;
  logic [35:0] hold;
  int          nres  = 0;
  int          nresh = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && bus.out_valid)
        check("y_stable", 64'({bus.y, bus.flags}),
              64'(hold));
      hold_v = bus.out_valid && !bus.out_ready;
      hold   = {bus.y, bus.flags};
      if (bus.out_valid && bus.out_ready) begin
        nres++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL spurious result %0h",
                   bus.y);
        end else begin
          e = q.pop_front();
          check($sformatf("result%0d", nres),
                64'({bus.y, bus.flags}), 64'(e));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rstn && bus_h.out_valid && bus_h.out_ready) begin
      nresh++;
      if (qh.size() == 0) begin
        total++;
        $display("FAIL spurious half result %0h",
                 bus_h.y);
      end else begin
        eh = qh.pop_front();
        check($sformatf("half%0d", nresh),
              64'({16'h0, bus_h.y, bus_h.flags}),
              64'(eh));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    nums = '{32'h00000000, 32'h3F800000,
             32'h40000000, 32'h40400000,
             32'h40800000, 32'h40A00000,
             32'h40C00000, 32'h40E00000,
             32'h41000000, 32'h41100000,
             32'h41200000, 32'h41300000};
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.op = 1'b0;
    bus.x1 = '0;
    bus.x2 = '0;
    bus.out_ready = 1'b1;
    bus_h.in_valid = 1'b0;
    bus_h.op = 1'b0;
    bus_h.x1 = '0;
    bus_h.x2 = '0;
    bus_h.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 0);
    check("rst_y", 64'(bus.y), 0);
    check("rst_flags", 64'(bus.flags), 0);
    check("rst_in_ready", 64'(bus.in_ready), 1);

    issue(0, 0, 32'h3F800000, 32'h40000000,
          32'h40400000, 4'h0);
    @(negedge clk);
    check("lat1", 64'(bus.out_valid), 0);
    @(negedge clk);
    check("lat2", 64'(bus.out_valid), 0);
    @(negedge clk);
    check("lat3", 64'(bus.out_valid), 1);
    drain();

    issue(0, 1, 32'h3F800000, 32'h3F7FFFFF,
          32'h33800000, 4'h0);
    issue(0, 1, 32'h3F800000, 32'h3F800000,
          32'h00000000, 4'h0);
    issue(0, 0, 32'h3F800000, 32'h33800000,
          32'h3F800000, 4'h1);
    issue(0, 0, 32'h3F800001, 32'h33800000,
          32'h3F800002, 4'h1);
    issue(0, 0, 32'h7F7FFFFF, 32'h7F7FFFFF,
          32'h7F800000, 4'h5);
    issue(0, 1, 32'h7F800000, 32'h7F800000,
          32'h7FC00000, 4'h8);
    issue(0, 0, 32'h7FC00000, 32'h3F800000,
          32'h7FC00000, 4'h0);
    issue(0, 0, 32'h7F800000, 32'h3F800000,
          32'h7F800000, 4'h0);
    issue(0, 1, 32'h40400000, 32'h3F800000,
          32'h40000000, 4'h0);
    issue(0, 0, 32'h3F800000, 32'hBF800000,
          32'h00000000, 4'h0);
    issue(0, 0, 32'h00000001, 32'h3F800000,
          32'h3F800000, 4'h0);
    issue(0, 1, 32'h00800000, 32'h00800001,
          32'h80000000, 4'h3);
    drain();

    fork
      begin
        for (int k = 1; k <= 10; k++)
          issue(0, 0, nums[k], nums[1],
                nums[k+1], 4'h0);
      end
      begin
        repeat (4) @(posedge clk);
        #2 bus.out_ready = 1'b0;
        repeat (4) @(negedge clk);
        check("stall_in_ready", 64'(bus.in_ready), 0);
        check("stall_out_valid",
              64'(bus.out_valid), 1);
        @(posedge clk);
        #2 bus.out_ready = 1'b1;
      end
    join
    drain();

    for (int k = 1; k <= 3; k++)
      issue(0, 0, nums[k], nums[1],
            nums[k+1], 4'h0);
    check("pre_rst_valid", 64'(bus.out_valid), 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.out_valid), 0);
    check("mid_rst_y", 64'(bus.y), 0);
    q.delete();
    qh.delete();
    @(posedge clk);
    @(posedge clk);
    #1 rstn = 1'b1;
    #1;
    check("post_rst_ready", 64'(bus.in_ready), 1);
    issue(0, 0, 32'h40000000, 32'h40000000,
          32'h40800000, 4'h0);
    drain();

    issue(1, 0, 32'h3C00, 32'h3C00, 32'h4000, 4'h0);
    issue(1, 1, 32'h3C00, 32'h3C00, 32'h0000, 4'h0);
    issue(1, 0, 32'h7BFF, 32'h7BFF, 32'h7C00, 4'h5);
    issue(1, 0, 32'h3C00, 32'h4000, 32'h4200, 4'h0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
